// File: rtl/tetris_key_pkg.sv
// tetris_key_pkg: command codes, key indices and the fixed serialization priority.
package tetris_key_pkg;
  localparam logic [2:0] CMD_NONE   = 3'd0;
  localparam logic [2:0] CMD_LEFT   = 3'd1;
  localparam logic [2:0] CMD_RIGHT  = 3'd2;
  localparam logic [2:0] CMD_ROTATE = 3'd3;
  localparam logic [2:0] CMD_DROP   = 3'd4;
  // Pending-mask bit positions; a higher index wins when several are pending.
  localparam int KEY_RIGHT  = 0;
  localparam int KEY_LEFT   = 1;
  localparam int KEY_ROTATE = 2;
  localparam int KEY_DROP   = 3;

  function automatic logic [3:0] key_pick(input logic [3:0] m);
    key_pick = '0;
    if (m[KEY_DROP]) key_pick[KEY_DROP] = 1'b1;
    else if (m[KEY_ROTATE]) key_pick[KEY_ROTATE] = 1'b1;
    else if (m[KEY_LEFT]) key_pick[KEY_LEFT] = 1'b1;
    else if (m[KEY_RIGHT]) key_pick[KEY_RIGHT] = 1'b1;
  endfunction

  function automatic logic [2:0] key_code(input logic [3:0] m);
    key_code = m[KEY_DROP]   ? CMD_DROP   :
               m[KEY_ROTATE] ? CMD_ROTATE :
               m[KEY_LEFT]   ? CMD_LEFT   :
               m[KEY_RIGHT]  ? CMD_RIGHT  : CMD_NONE;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: show-ahead synchronous FIFO; a push into a full FIFO is taken only alongside a pop.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_push, w_pop;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/key_cmd_queue.sv
// key_cmd_queue: turns key-press pulses into a prioritized command stream buffered for game logic.
module key_cmd_queue import tetris_key_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   key_left,
  input  logic                   key_right,
  input  logic                   key_rotate,
  input  logic                   key_drop,
  input  logic                   cmd_ready,
  output logic                   cmd_valid,
  output logic [2:0]             cmd_code,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       drop_cnt
);
  logic [3:0]       r_pend, w_keys, w_take, w_merge;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_sum;
  logic [2:0]       w_code;
  logic             w_full, w_empty, w_pop, w_push;
  assign w_keys    = {key_drop, key_rotate, key_left, key_right};
  assign cmd_valid = ~w_empty;
  assign w_pop     = cmd_valid & cmd_ready;
  assign w_push    = |r_pend & (~w_full | w_pop);
  assign w_take    = w_push ? key_pick(r_pend) : '0;
  assign w_code    = key_code(r_pend);
  // A press on a bit that stays pending this cycle is absorbed and counted as lost.
  assign w_merge   = w_keys & r_pend & ~w_take;
  assign w_sum     = {1'b0, r_cnt} + (CNT_W+1)'($countones(w_merge));
  assign drop_cnt  = r_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= (r_pend & ~w_take) | w_keys;
      r_cnt  <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
  end
  cmd_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_code),
    .o_data  (cmd_code),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );
endmodule

// File: tb/tb_key_cmd_queue.sv
// tb_key_cmd_queue: scenario tasks plus a negedge scoreboard monitor for popped commands.
module tb_key_cmd_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   cmd_ready = 1'b0;
  logic [3:0]             keys = '0;
  logic                   cmd_valid;
  logic [2:0]             cmd_code;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       drop_cnt;
  logic [2:0]             exp_q [$];
  logic [2:0]             mon_exp;
  int                     errors = 0;
  int                     checks = 0;

  always #5 clk = ~clk;

  key_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_left   (keys[1]),
    .key_right  (keys[0]),
    .key_rotate (keys[2]),
    .key_drop   (keys[3]),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt)
  );

  // keys index: 0=right 1=left 2=rotate 3=drop
  function automatic logic [2:0] code_of(input int idx);
    return idx == 3 ? 3'd4 : idx == 2 ? 3'd3 : idx == 1 ? 3'd1 : 3'd2;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1);
    step(1);
    cmd_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got code %0d, expected no command", cmd_code);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cmd_code !== mon_exp) begin
          errors++;
          $display("FAIL pop_order: got code %0d, expected %0d", cmd_code, mon_exp);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d expected 0", cmd_valid); end
    checks++; if (cmd_code !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d expected 0", cmd_code); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_single();
    keys = 4'b0010;
    exp_q.push_back(3'd1);
    step(1);
    keys = '0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL single_early: got valid %0d expected 0", cmd_valid); end
    step(1);
    checks++; if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin errors++; $display("FAIL single_head: got valid %0d code %0d expected 1/1", cmd_valid, cmd_code); end
    checks++; if (fifo_count !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0 || fifo_count !== 0) begin errors++; $display("FAIL single_pop: got valid %0d count %0d expected 0/0", cmd_valid, fifo_count); end
  endtask

  task automatic test_all_four();
    logic [2:0] order [4] = '{3'd4, 3'd3, 3'd1, 3'd2};
    cmd_ready = 1'b1;
    keys = 4'b1111;
    foreach (order[i]) exp_q.push_back(order[i]);
    step(1);
    keys = '0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (cmd_valid !== 1'b1 || cmd_code !== order[i]) begin errors++; $display("FAIL all4_seq%0d: got valid %0d code %0d expected 1/%0d", i, cmd_valid, cmd_code, order[i]); end
    end
    step(1);
    cmd_ready = 1'b0;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL all4_empty: got valid %0d expected 0", cmd_valid); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL all4_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_stall();
    int seq [6] = '{3, 2, 1, 0, 1, 2};
    cmd_ready = 1'b0;
    foreach (seq[i]) begin
      keys = 4'b0001 << seq[i];
      step(1);
      keys = '0;
    end
    // LEFT and ROTATE are both held pending when the drain starts, so ROTATE goes first.
    foreach (seq[i]) exp_q.push_back(i < 4 ? code_of(seq[i]) : (i == 4 ? 3'd3 : 3'd1));
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (cmd_code !== 3'd4 || fifo_count !== 4) begin errors++; $display("FAIL stall_hold%0d: got code %0d count %0d expected 4/4", i, cmd_code, fifo_count); end
    end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL stall_drop: got %0d expected 0", drop_cnt); end
    drain();
    checks++; if (exp_q.size() != 0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %0d left, valid %0d expected 0/0", exp_q.size(), cmd_valid); end
  endtask

  task automatic test_back_to_back();
    int idx;
    int bad = 0;
    for (int i = 0; i < 16; i++) begin
      idx = $urandom_range(0, 3);
      keys = 4'b0001 << idx;
      exp_q.push_back(code_of(idx));
      cmd_ready = (i >= 5);
      step(1);
      keys = '0;
      if (i >= 5 && fifo_count !== 4) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_full_count: got %0d cycles off 4, expected 0", bad); end
    drain();
    checks++; if (exp_q.size() != 0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %0d left, valid %0d expected 0/0", exp_q.size(), cmd_valid); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL b2b_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_saturate();
    cmd_ready = 1'b0;
    keys = 4'b0010;
    repeat (4) exp_q.push_back(3'd1);
    step(4);
    keys = '0;
    step(2);
    checks++; if (fifo_count !== 4 || drop_cnt !== '0) begin errors++; $display("FAIL sat_fill: got count %0d drop %0d expected 4/0", fifo_count, drop_cnt); end
    keys = 4'b1111;
    exp_q.push_back(3'd4); exp_q.push_back(3'd3); exp_q.push_back(3'd1); exp_q.push_back(3'd2);
    step(1);
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL sat_first_hold: got %0d expected 0", drop_cnt); end
    step(1);
    checks++; if (drop_cnt !== 4) begin errors++; $display("FAIL sat_multi_merge: got %0d expected 4", drop_cnt); end
    keys = 4'b0100;
    step(1);
    checks++; if (drop_cnt !== 5) begin errors++; $display("FAIL sat_one_merge: got %0d expected 5", drop_cnt); end
    step(295);
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_max: got %0d expected 255", drop_cnt); end
    step(1);
    keys = '0;
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold: got %0d expected 255", drop_cnt); end
    drain();
    checks++; if (exp_q.size() != 0 || cmd_valid !== 1'b0) begin errors++; $display("FAIL sat_drain: got %0d left, valid %0d expected 0/0", exp_q.size(), cmd_valid); end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_after_drain: got %0d expected 255", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    cmd_ready = 1'b0;
    keys = 4'b1000; step(1);
    keys = 4'b0001; step(1);
    keys = 4'b0010; step(1);
    keys = 4'b0110; step(1);
    keys = '0;
    checks++; if (fifo_count !== 3) begin errors++; $display("FAIL rstmid_pre: got count %0d expected 3", fifo_count); end
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    checks++; if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin errors++; $display("FAIL rstmid_valid: got valid %0d code %0d expected 0/0", cmd_valid, cmd_code); end
    checks++; if (fifo_count !== 0 || drop_cnt !== '0) begin errors++; $display("FAIL rstmid_counts: got count %0d drop %0d expected 0/0", fifo_count, drop_cnt); end
    cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (cmd_valid !== 1'b0) stale++;
    end
    cmd_ready = 1'b0;
    checks++; if (stale != 0) begin errors++; $display("FAIL rstmid_stale: got %0d cycles with valid, expected 0", stale); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
